mc_ctrl_hs: RTL

Parametrised multicycle MIPS control unit with a memory ready handshake. It drives the multicycle datapath's strobes and multiplexer selects, and sits between the instruction register fields and the datapath inside the core top. It extends the basic multicycle controller with several additions:
- memory wait states via a `memreq`/`memready` handshake;
- a bus-timeout error state;
- optional `addi`, `bne` and `j` support;
- illegal-instruction reporting.

---
 rtl/mc_ctrl_hs.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multicycle MIPS control unit. The memory states wait on a
// memreq/memready handshake and are guarded by a bus timeout. It optionally
// supports addi/bne/j and flags illegal instructions.
module mc_ctrl_hs #(
    parameter int TIMEOUT = 16,
    parameter bit EXT_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       memreq,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic       lord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic       buserr
);

    // Keep at least one counter bit so that TIMEOUT=0 still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW:0] TO_VAL = (CW + 1)'(TIMEOUT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_ERROR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [5:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic            r_buserr;
    logic [CW:0]     w_cnt_inc;
    logic            w_wait;
    logic            w_funct_ok;
    logic [2:0]      w_alu_f;
    logic            w_memreq, w_memwrite, w_regwrite, w_irwrite, w_pcen, w_illegal;

    assign w_wait    = ((r_state == S_FETCH) || (r_state == S_MEMRD) ||
                        (r_state == S_MEMWR)) && !memready;
    assign w_cnt_inc = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Opcode latch, wait-cycle counter and sticky bus error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= 6'd0;
            r_cnt    <= '0;
            r_buserr <= 1'b0;
        end else begin
            if (r_state == S_DECODE) r_op <= op;
            if (w_next != r_state)   r_cnt <= '0;
            else if (w_wait)         r_cnt <= w_cnt_inc[CW-1:0];
            if (w_next == S_ERROR)   r_buserr <= 1'b1;
        end
    end

    // Function-field decode for R-type ALU operations.
    always_comb begin
        w_funct_ok = 1'b1;
        w_alu_f    = 3'b010;
        case (funct)
            6'b100000: w_alu_f = 3'b010;
            6'b100010: w_alu_f = 3'b110;
            6'b100100: w_alu_f = 3'b000;
            6'b100101: w_alu_f = 3'b001;
            6'b101010: w_alu_f = 3'b111;
            default:   w_funct_ok = 1'b0;
        endcase
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        w_next     = r_state;
        w_memreq   = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_pcen     = 1'b0;
        w_illegal  = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        lord       = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
        case (r_state)
            S_FETCH: begin
                w_memreq  = 1'b1;
                alusrcb   = 2'b01;
                w_irwrite = memready;
                w_pcen    = memready;
                if (memready) w_next = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                w_next  = S_FETCH;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE: if (w_funct_ok) w_next = S_EXEC; else w_illegal = 1'b1;
                    OP_BEQ:   w_next = S_BRANCH;
                    OP_BNE:   if (EXT_EN) w_next = S_BRANCH; else w_illegal = 1'b1;
                    OP_ADDI:  if (EXT_EN) w_next = S_ADDIEX; else w_illegal = 1'b1;
                    OP_J:     if (EXT_EN) w_next = S_JUMP;   else w_illegal = 1'b1;
                    default:  w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_memreq = 1'b1;
                lord     = 1'b1;
                if (memready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                memtoreg   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_memreq   = 1'b1;
                w_memwrite = 1'b1;
                lord       = 1'b1;
                if (memready) w_next = S_FETCH;
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                alucontrol = w_alu_f;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                regdst     = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                w_pcen     = (r_op == OP_BNE) ? !zero : zero;
                w_next     = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                pcsrc  = 2'b10;
                w_pcen = 1'b1;
                w_next = S_FETCH;
            end
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_FETCH;
        endcase
        // Bus timeout: the final wait cycle that still sees no memready.
        if (w_wait && (TIMEOUT != 0) && (w_cnt_inc == TO_VAL)) w_next = S_ERROR;
    end

    // Strobes are held off while reset is asserted.
    assign memreq   = w_memreq   & ~reset;
    assign memwrite = w_memwrite & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign irwrite  = w_irwrite  & ~reset;
    assign pcen     = w_pcen     & ~reset;
    assign illegal  = w_illegal  & ~reset;
    assign buserr   = r_buserr;

endmodule
